// File: rtl/icache_loader.sv
// icache_loader: parses a framed byte stream into 16-bit icache writes; ICACHE_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module icache_loader #(
  parameter int unsigned DEPTH      = 1000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned BASE_INDEX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        download_program,
  output logic [31:0] instruction_index,
  output logic [15:0] instruction,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
`ifdef ICACHE_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;
  // state entered once the last instruction (or an empty image) has been consumed
  localparam state_t TAIL =
`ifdef ICACHE_LOADER_CHECKSUM_EN
    CHECK;
`else
    DONE;
`endif
  state_t      state_q, state_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d, instr_q, instr_d, len_w;
  logic [7:0]  hi_q, hi_d;
  logic [31:0] idx_q, idx_d;
  logic        take, sync;
  assign byte_ready        = (state_q != WRITE) && (state_q != DONE);
  assign take              = byte_valid && byte_ready;
  assign sync              = take && (byte_data == SYNC_BYTE);
  assign len_w             = {len_q[15:8], byte_data};
  assign download_program  = state_q == WRITE;
  assign instruction_index = idx_q;
  assign instruction       = instr_q;
  assign cpu_hold          = (state_q != IDLE) && (state_q != DONE);
  assign done              = state_q == DONE;
  assign error             = state_q == ERROR;
`ifdef ICACHE_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  assign sum_d = sync && (state_q == IDLE || state_q == ERROR) ? 8'h00 :
                 take && (state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO}) ? sum_q ^ byte_data : sum_q;
  always_ff @(posedge clk) sum_q <= rst ? 8'h00 : sum_d;
`endif
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    instr_d = instr_q;
    case (state_q)
      IDLE, ERROR: state_d = sync ? LEN_HI : state_q;
      LEN_HI: if (take) begin
        len_d[15:8] = byte_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (take) begin
        len_d   = len_w;
        cnt_d   = 16'd0;
        state_d = 32'(len_w) > DEPTH ? ERROR : len_w == 16'd0 ? TAIL : DATA_HI;
      end
      DATA_HI: if (take) begin
        hi_d    = byte_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (take) begin
        instr_d = {hi_q, byte_data};
        idx_d   = BASE_INDEX + 32'(cnt_q);
        state_d = WRITE;
      end
      WRITE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_q + 16'd1 == len_q) ? TAIL : DATA_HI;
      end
`ifdef ICACHE_LOADER_CHECKSUM_EN
      CHECK: if (take) state_d = (sum_q ^ byte_data) == 8'h00 ? DONE : ERROR;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      idx_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      instr_q <= instr_d;
    end
  end
endmodule
